// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the serial-stream blocks: FSM encoding and default word width.
package serial_bit_feeder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic {
    StIdle,
    StShift
  } feeder_state_e;

endpackage

// File: rtl/serial_feeder_shifter.sv
// Shift register and bit counter for the serial feeder; selects bit order and flags the last bit.
module serial_feeder_shifter
  import serial_bit_feeder_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clock0,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             active,
  output logic             bit_out,
  output logic             frame_done
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign frame_done = active && (cnt_q == LastCnt);
  assign bit_out    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = load_word;
      cnt_d   = '0;
    end else if (active) begin
      shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      // Wrap explicitly so the counter never passes WIDTH-1 for non-power-of-two widths.
      cnt_d   = frame_done ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock0 or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: ready/valid word input, one pending word of buffering, gapless output.
module serial_bit_feeder
  import serial_bit_feeder_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clock0,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_done,
  output logic             underrun
);

  feeder_state_e    state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             underrun_q, underrun_d;

  logic             xfer;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic             active;
  logic             last;
  logic             shift_bit;

  // Ready depends only on registered state, so there is no path from data_valid.
  assign data_ready = !rst && !pend_full_q;
  assign xfer       = data_valid && data_ready;
  assign active     = (state_q == StShift);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    underrun_d  = 1'b0;
    load        = 1'b0;
    load_word   = data_in;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (last) begin
          if (pend_full_q) begin
            load        = 1'b1;
            load_word   = pend_q;
            pend_full_d = 1'b0;
          end else if (xfer) begin
            load = 1'b1;
          end else begin
            state_d    = StIdle;
            underrun_d = 1'b1;
          end
        end else if (xfer) begin
          pend_d      = data_in;
          pend_full_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock0 or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      underrun_q  <= underrun_d;
    end
  end

  serial_feeder_shifter #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shifter (
    .clock0    (clock0),
    .rst       (rst),
    .load      (load),
    .load_word (load_word),
    .active    (active),
    .bit_out   (shift_bit),
    .frame_done(last)
  );

  assign serial_out   = active ? shift_bit : IDLE_BIT;
  assign serial_valid = active;
  assign frame_done   = last;
  assign underrun     = underrun_q;

endmodule
